subpel_interp_stream: RTL and testbench



---
 rtl/subpel_interp_stream.sv | 144 ++++++++++++++
 tb/tb_subpel_interp_stream.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/subpel_interp_stream.sv
// subpel_interp_stream: streaming 8-tap luma sub-pel interpolator with internal edge replication.
// Optional macro APPROX_TAPS_EN masks tap input LSBs when approx_mode is high.
module subpel_interp_stream #(
  parameter int PIX_W      = 8,
  parameter int ROW_LEN    = 16,
  parameter int SHIFT      = 6,
  parameter int APPROX_LSB = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_full,
  output logic [PIX_W-1:0] out_q1,
  output logic [PIX_W-1:0] out_h,
  output logic [PIX_W-1:0] out_q3,
  output logic             out_last,
  output logic             busy,
  input  logic             approx_mode
);
  localparam int ACC_W = PIX_W + 8;
  localparam int CW = $clog2(ROW_LEN + 1);
  // Coefficients indexed by window slot s0..s7
  localparam logic signed [7:0] CQ1 [8] = '{8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};
  localparam logic signed [7:0] CH  [8] = '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
  localparam logic signed [7:0] CQ3 [8] = '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic [PIX_W-1:0]  win_q [8];
  logic [PIX_W-1:0]  win_d [8];
  logic              valid_q, last_q;
  logic [PIX_W-1:0]  full_q, q1_q, h_q, q3_q;
  logic              adv, acc, load, shift, emit;
  logic [PIX_W-1:0]  mask, px;
  logic signed [ACC_W-1:0] sx, sq1, sh, sq3;

  function automatic logic [PIX_W-1:0] clip(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] r;
    r = (s + ACC_W'(2 ** (SHIFT - 1))) >>> SHIFT;
    return (r < 0) ? '0 : (r > ACC_W'(2 ** PIX_W - 1)) ? '1 : r[PIX_W-1:0];
  endfunction

`ifdef APPROX_TAPS_EN
  assign mask = approx_mode ? ~PIX_W'((1 << APPROX_LSB) - 1) : '1;
`else
  logic [1:0] unused_cfg;
  assign unused_cfg = {approx_mode, 1'(APPROX_LSB)};
  assign mask = '1;
`endif

  assign adv       = !valid_q || out_ready;
  assign in_ready  = adv && state_q != DRAIN;
  assign acc       = in_valid && in_ready;
  assign busy      = state_q != IDLE;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_full  = full_q;
  assign out_q1    = q1_q;
  assign out_h     = h_q;
  assign out_q3    = q3_q;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dcnt_d = dcnt_q;
    load = 1'b0;
    shift = 1'b0;
    emit = 1'b0;
    case (state_q)
      IDLE: if (acc) begin
        load = 1'b1;
        cnt_d = CW'(1);
        state_d = FILL;
      end
      FILL, STREAM: if (acc) begin
        shift = 1'b1;
        cnt_d = cnt_q + CW'(1);
        dcnt_d = '0;
        emit = state_q == STREAM || cnt_d == CW'(5);
        state_d = (cnt_d == CW'(ROW_LEN)) ? DRAIN : (cnt_d == CW'(5)) ? STREAM : state_q;
      end
      default: if (adv) begin
        shift = 1'b1;
        emit = 1'b1;
        dcnt_d = dcnt_q + 2'd1;
        state_d = (dcnt_q == 2'd3) ? IDLE : DRAIN;
        cnt_d = (dcnt_q == 2'd3) ? '0 : cnt_q;
      end
    endcase
    // Drain replicates the right-edge pixel; IDLE load replicates the left edge
    win_d[0] = (load || shift) ? ((state_q == DRAIN) ? win_q[0] : in_data) : win_q[0];
    for (int i = 1; i < 8; i++) win_d[i] = load ? in_data : shift ? win_q[i-1] : win_q[i];
  end

  always_comb begin
    sq1 = '0;
    sh = '0;
    sq3 = '0;
    px = '0;
    sx = '0;
    for (int i = 0; i < 8; i++) begin
      px = win_d[i] & mask;
      sx = ACC_W'(px);
      sq1 = sq1 + sx * ACC_W'(CQ1[i]);
      sh = sh + sx * ACC_W'(CH[i]);
      sq3 = sq3 + sx * ACC_W'(CQ3[i]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dcnt_q <= '0;
      win_q <= '{default: '0};
      valid_q <= 1'b0;
      last_q <= 1'b0;
      full_q <= '0;
      q1_q <= '0;
      h_q <= '0;
      q3_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dcnt_q <= dcnt_d;
      win_q <= win_d;
      valid_q <= emit || (valid_q && !out_ready);
      last_q <= emit ? (state_q == DRAIN && dcnt_q == 2'd3) : (last_q && !out_ready);
      if (emit) begin
        full_q <= win_d[4];
        q1_q <= clip(sq1);
        h_q <= clip(sh);
        q3_q <= clip(sq3);
      end
    end
  end
endmodule

// File: tb/tb_subpel_interp_stream.sv
// tb_subpel_interp_stream: scoreboard bench for subpel_interp_stream with directed rows.
module tb_subpel_interp_stream;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_full, out_q1, out_h, out_q3;
  logic       out_last, busy;
  logic       approx_mode = 1'b0;

  typedef struct packed {logic [7:0] f, q1, h, q3; logic last;} bnd_t;
  bnd_t exp_q[$];
  bnd_t mon_a, mon_e;
  int total = 0, bad = 0, taken = 0;

  subpel_interp_stream dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_full(out_full), .out_q1(out_q1), .out_h(out_h), .out_q3(out_q3),
    .out_last(out_last), .busy(busy), .approx_mode(approx_mode)
  );

  always #5 clock = ~clock;

  // Step row: x0..x7=0, x8..x15=255
  logic [7:0] st_f  [16] = '{0,0,0,0,0,0,0,0,255,255,255,255,255,255,255,255};
  logic [7:0] st_q1 [16] = '{0,0,0,0,0,4,0,52,255,243,255,255,255,255,255,255};
  logic [7:0] st_h  [16] = '{0,0,0,0,0,12,0,128,255,243,255,255,255,255,255,255};
  logic [7:0] st_q3 [16] = '{0,0,0,0,0,12,0,203,255,251,255,255,255,255,255,255};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic push_flat(input logic [7:0] f, input logic [7:0] v);
    for (int i = 0; i < 16; i++) exp_q.push_back('{f, v, v, v, i == 15});
  endtask

  task automatic push_px(input logic [7:0] d, output logic was_idle);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clock);
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    was_idle = !busy;
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got=in_ready0 want=in_ready1");
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clock);
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    repeat (4) @(posedge clock);
    #1;
  endtask

  initial forever begin
    @(negedge clock);
    if (reset_n && out_valid && out_ready) begin
      mon_a = '{out_full, out_q1, out_h, out_q3, out_last};
      taken++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_bundle got=%h want=none", mon_a);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          bad++;
          $display("FAIL bundle got=%h want=%h", mon_a, mon_e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic idle;
    logic [31:0] snap;
    logic [7:0] av;
    int base;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data", {out_full, out_q1, out_h, out_q3}, 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    base = taken;
    push_flat(100, 100);
    for (int i = 0; i < 16; i++) begin
      push_px(100, idle);
      if (i == 3) chk("lat_before", out_valid, 0);
      if (i == 4) chk("lat_after", out_valid, 1);
    end
    wait_empty("flat");
    chk("flat_count", taken - base, 16);

    base = taken;
    for (int i = 0; i < 16; i++) exp_q.push_back('{st_f[i], st_q1[i], st_h[i], st_q3[i], i == 15});
    for (int i = 0; i < 16; i++) push_px((i < 8) ? 8'd0 : 8'd255, idle);
    wait_empty("step");
    chk("step_count", taken - base, 16);

    base = taken;
    push_flat(100, 100);
    fork
      for (int i = 0; i < 16; i++) push_px(100, idle);
      begin
        int n;
        n = 0;
        do begin
          @(posedge clock);
          n++;
        end while (taken - base < 5 && n < 200);
        #1 out_ready = 1'b0;
        snap = {out_full, out_q1, out_h, out_q3};
        repeat (3) begin
          @(negedge clock);
          chk("stall_valid", out_valid, 1);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_hold", {out_full, out_q1, out_h, out_q3}, snap);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    wait_empty("stall");
    chk("stall_count", taken - base, 16);

    base = taken;
    push_flat(50, 50);
    push_flat(200, 200);
    for (int i = 0; i < 16; i++) push_px(50, idle);
    push_px(200, idle);
    chk("row2_idle", idle, 1);
    for (int i = 1; i < 16; i++) push_px(200, idle);
    wait_empty("b2b");
    chk("b2b_count", taken - base, 32);

    push_flat(30, 30);
    for (int i = 0; i < 9; i++) push_px(30, idle);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("midrst_quiet", out_valid, 0);
    base = taken;
    push_flat(70, 70);
    for (int i = 0; i < 16; i++) push_px(70, idle);
    wait_empty("after_rst");
    chk("after_rst_count", taken - base, 16);

`ifdef APPROX_TAPS_EN
    av = 8'd100;
`else
    av = 8'd103;
`endif
    approx_mode = 1'b1;
    base = taken;
    push_flat(103, av);
    for (int i = 0; i < 16; i++) push_px(103, idle);
    wait_empty("approx_on");
    chk("approx_on_count", taken - base, 16);
    approx_mode = 1'b0;
    base = taken;
    push_flat(103, 103);
    for (int i = 0; i < 16; i++) push_px(103, idle);
    wait_empty("approx_off");
    chk("approx_off_count", taken - base, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
